// File: rtl/acc_unit_pkg.sv
// Shared encodings for the accumulator stage: ALU control codes, phase names,
// OPR codes and accumulator-group OPA codes, plus the two-word instruction test.
package acc_unit_pkg;

    localparam logic [2:0] ALU_OP_PASS  = 3'd0;
    localparam logic [2:0] ALU_OP_ADD   = 3'd1;
    localparam logic [2:0] ALU_OP_ROL   = 3'd2;
    localparam logic [2:0] ALU_OP_ROR   = 3'd3;
    localparam logic [2:0] ALU_OP_DEC_A = 3'd4;
    localparam logic [2:0] ALU_OP_LG2_1 = 3'd5;

    localparam logic [2:0] ALU_IN0_ACC  = 3'd0;
    localparam logic [2:0] ALU_IN0_REG  = 3'd1;
    localparam logic [2:0] ALU_IN0_DATA = 3'd2;
    localparam logic [2:0] ALU_IN0_ZERO = 3'd3;

    localparam logic [1:0] ALU_IN1_REG  = 2'd0;
    localparam logic [1:0] ALU_IN1_NREG = 2'd1;
    localparam logic [1:0] ALU_IN1_ONE  = 2'd2;
    localparam logic [1:0] ALU_IN1_K14  = 2'd3;

    localparam logic [1:0] ALU_CIN_CARRY  = 2'd0;
    localparam logic [1:0] ALU_CIN_NCARRY = 2'd1;
    localparam logic [1:0] ALU_CIN_ZERO   = 2'd2;
    localparam logic [1:0] ALU_CIN_ONE    = 2'd3;

    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    typedef enum logic [3:0] {
        OPR_NOP     = 4'h0,
        OPR_JCN     = 4'h1,
        OPR_FIM_SRC = 4'h2,
        OPR_FIN_JIN = 4'h3,
        OPR_JUN     = 4'h4,
        OPR_JMS     = 4'h5,
        OPR_INC     = 4'h6,
        OPR_ISZ     = 4'h7,
        OPR_ADD     = 4'h8,
        OPR_SUB     = 4'h9,
        OPR_LD      = 4'hA,
        OPR_XCH     = 4'hB,
        OPR_BBL     = 4'hC,
        OPR_LDM     = 4'hD,
        OPR_IO_GRP  = 4'hE,
        OPR_ACC_GRP = 4'hF
    } opr_t;

    localparam logic [3:0] ACC_CLB = 4'h0;
    localparam logic [3:0] ACC_CLC = 4'h1;
    localparam logic [3:0] ACC_IAC = 4'h2;
    localparam logic [3:0] ACC_CMC = 4'h3;
    localparam logic [3:0] ACC_CMA = 4'h4;
    localparam logic [3:0] ACC_RAL = 4'h5;
    localparam logic [3:0] ACC_RAR = 4'h6;
    localparam logic [3:0] ACC_TCC = 4'h7;
    localparam logic [3:0] ACC_DAC = 4'h8;
    localparam logic [3:0] ACC_TCS = 4'h9;
    localparam logic [3:0] ACC_STC = 4'hA;
    localparam logic [3:0] ACC_DAA = 4'hB;
    localparam logic [3:0] ACC_KBP = 4'hC;

    // JCN, JUN, JMS, ISZ and FIM (OPR=2 with even OPA) carry a second instruction word.
    function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
        return (opr == OPR_JCN) || (opr == OPR_JUN) || (opr == OPR_JMS) ||
               (opr == OPR_ISZ) || ((opr == OPR_FIM_SRC) && !opa[0]);
    endfunction

endpackage

// File: rtl/acc_unit_cycle_timer.sv
// Eight-phase instruction-cycle counter; sync forces the next phase to A1.
module cycle_timer
    import acc_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync,
    output logic [2:0] phase
);

    logic [2:0] phase_reg;
    logic [2:0] phase_next;

    always_comb begin
        phase_next = sync ? PH_A1 : phase_reg + 3'd1;
    end

    // Reset parks at X3 so the first clock after release lands on A1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= PH_X3;
        end else begin
            phase_reg <= phase_next;
        end
    end

    assign phase = phase_reg;

endmodule

// File: rtl/acc_unit.sv
// Accumulator/carry stage around the 4-bit ALU: OPR/OPA latching, ALU control decode
// and X2 writeback. Define ACC_ASSERT_EN to enable simulation-only protocol assertions.
module acc_unit
    import acc_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync,
    input  logic [3:0] data_in,
    input  logic [3:0] regval,
    input  logic [4:0] alu_result,
    output logic [2:0] alu_op,
    output logic [2:0] alu_in0_sel,
    output logic [1:0] alu_in1_sel,
    output logic [1:0] alu_cin_sel,
    output logic [3:0] alu_data,
    output logic [3:0] acc,
    output logic       carry,
    output logic       reg_we,
    output logic [3:0] reg_wdata,
    output logic [2:0] phase
);

    logic [2:0] phase_cur;
    logic [3:0] opr_reg, opa_reg;
    logic [3:0] acc_reg, acc_next;
    logic       carry_reg, carry_next;
    logic       second_word_reg;
    logic       reg_we_reg, reg_we_next;
    logic [3:0] reg_wdata_reg, reg_wdata_next;
    logic [3:0] opr_eff, opa_eff;
    logic       in_exec;

    cycle_timer u_cycle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .sync  (sync),
        .phase (phase_cur)
    );

    // The operand word of a two-word instruction must not execute as an opcode.
    assign opr_eff = second_word_reg ? 4'(OPR_NOP) : opr_reg;
    assign opa_eff = second_word_reg ? 4'h0 : opa_reg;
    assign in_exec = (phase_cur == PH_X1) || (phase_cur == PH_X2);

    always_comb begin
        alu_op      = ALU_OP_PASS;
        alu_in0_sel = ALU_IN0_ACC;
        alu_in1_sel = ALU_IN1_REG;
        alu_cin_sel = ALU_CIN_CARRY;
        if (in_exec) begin
            case (opr_eff)
                OPR_ADD: alu_op = ALU_OP_ADD;
                OPR_SUB: begin
                    alu_op      = ALU_OP_ADD;
                    alu_in1_sel = ALU_IN1_NREG;
                    alu_cin_sel = ALU_CIN_NCARRY;
                end
                OPR_INC: begin
                    alu_op      = ALU_OP_ADD;
                    alu_in0_sel = ALU_IN0_REG;
                    alu_in1_sel = ALU_IN1_ONE;
                    alu_cin_sel = ALU_CIN_ZERO;
                end
                OPR_LD, OPR_XCH: alu_in0_sel = ALU_IN0_REG;
                OPR_LDM:         alu_in0_sel = ALU_IN0_DATA;
                OPR_ACC_GRP: begin
                    case (opa_eff)
                        ACC_IAC: begin
                            alu_op      = ALU_OP_ADD;
                            alu_in1_sel = ALU_IN1_ONE;
                            alu_cin_sel = ALU_CIN_ZERO;
                        end
                        ACC_DAC: begin
                            alu_op      = ALU_OP_ADD;
                            alu_in1_sel = ALU_IN1_K14;
                            alu_cin_sel = ALU_CIN_ONE;
                        end
                        ACC_RAL: alu_op = ALU_OP_ROL;
                        ACC_RAR: alu_op = ALU_OP_ROR;
                        ACC_DAA: alu_op = ALU_OP_DEC_A;
                        ACC_KBP: alu_op = ALU_OP_LG2_1;
                        default: alu_op = ALU_OP_PASS;
                    endcase
                end
                default: alu_op = ALU_OP_PASS;
            endcase
        end
    end

    // A sync during X2 abandons the instruction, so the writeback edge is suppressed.
    always_comb begin
        acc_next       = acc_reg;
        carry_next     = carry_reg;
        reg_we_next    = 1'b0;
        reg_wdata_next = reg_wdata_reg;
        if ((phase_cur == PH_X2) && !sync) begin
            case (opr_eff)
                OPR_ADD, OPR_SUB: begin
                    acc_next   = alu_result[3:0];
                    carry_next = alu_result[4];
                end
                OPR_LD, OPR_LDM: acc_next = alu_result[3:0];
                OPR_XCH: begin
                    acc_next       = alu_result[3:0];
                    reg_we_next    = 1'b1;
                    reg_wdata_next = acc_reg;
                end
                OPR_INC: begin
                    reg_we_next    = 1'b1;
                    reg_wdata_next = alu_result[3:0];
                end
                OPR_ACC_GRP: begin
                    case (opa_eff)
                        ACC_CLB: begin
                            acc_next   = 4'h0;
                            carry_next = 1'b0;
                        end
                        ACC_CLC: carry_next = 1'b0;
                        ACC_IAC, ACC_RAL, ACC_RAR, ACC_DAC, ACC_DAA: begin
                            acc_next   = alu_result[3:0];
                            carry_next = alu_result[4];
                        end
                        ACC_CMC: carry_next = ~carry_reg;
                        ACC_CMA: acc_next = ~acc_reg;
                        ACC_TCC: begin
                            acc_next   = {3'b000, carry_reg};
                            carry_next = 1'b0;
                        end
                        ACC_TCS: begin
                            acc_next   = carry_reg ? 4'd10 : 4'd9;
                            carry_next = 1'b0;
                        end
                        ACC_STC: carry_next = 1'b1;
                        ACC_KBP: acc_next = alu_result[3:0];
                        default: acc_next = acc_reg;
                    endcase
                end
                default: acc_next = acc_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opr_reg         <= 4'h0;
            opa_reg         <= 4'h0;
            acc_reg         <= 4'h0;
            carry_reg       <= 1'b0;
            second_word_reg <= 1'b0;
            reg_we_reg      <= 1'b0;
            reg_wdata_reg   <= 4'h0;
        end else begin
            if (phase_cur == PH_M1) opr_reg <= data_in;
            if (phase_cur == PH_M2) opa_reg <= data_in;
            if (phase_cur == PH_X3) begin
                second_word_reg <= second_word_reg ? 1'b0 : is_two_word(opr_reg, opa_reg);
            end
            acc_reg       <= acc_next;
            carry_reg     <= carry_next;
            reg_we_reg    <= reg_we_next;
            reg_wdata_reg <= reg_wdata_next;
        end
    end

    assign alu_data  = opa_reg;
    assign acc       = acc_reg;
    assign carry     = carry_reg;
    assign reg_we    = reg_we_reg;
    assign reg_wdata = reg_wdata_reg;
    assign phase     = phase_cur;

`ifdef ACC_ASSERT_EN
    logic running_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_reg <= 1'b0;
        end else if (sync && (phase_cur == PH_X3)) begin
            running_reg <= 1'b1;
        end
    end

    a_alu_known: assert property (@(posedge clk) disable iff (!rst_n)
        ((phase_cur == PH_X2) && !second_word_reg) |-> !$isunknown(alu_result));

    a_sync_period: assert property (@(posedge clk) disable iff (!rst_n)
        (sync && running_reg) |-> (phase_cur == PH_X3));

    a_reg_we_window: assert property (@(posedge clk) disable iff (!rst_n)
        reg_we_reg |-> (phase_cur == PH_X3));
`endif

endmodule

// File: tb/tb_acc_unit.sv
// Directed bench for acc_unit: a behavioural ALU closes the loop, each task checks one feature.
module tb_acc_unit;
    import acc_unit_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       sync;
    logic [3:0] data_in;
    logic [3:0] regval;
    logic [4:0] alu_result;
    logic [2:0] alu_op;
    logic [2:0] alu_in0_sel;
    logic [1:0] alu_in1_sel;
    logic [1:0] alu_cin_sel;
    logic [3:0] alu_data;
    logic [3:0] acc;
    logic       carry;
    logic       reg_we;
    logic [3:0] reg_wdata;
    logic [2:0] phase;

    int vectors = 0;
    int errors  = 0;
    int we_cnt;
    int we_idx;
    logic [3:0] we_data;

    acc_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sync        (sync),
        .data_in     (data_in),
        .regval      (regval),
        .alu_result  (alu_result),
        .alu_op      (alu_op),
        .alu_in0_sel (alu_in0_sel),
        .alu_in1_sel (alu_in1_sel),
        .alu_cin_sel (alu_cin_sel),
        .alu_data    (alu_data),
        .acc         (acc),
        .carry       (carry),
        .reg_we      (reg_we),
        .reg_wdata   (reg_wdata),
        .phase       (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4-bit ALU driven by the unit's control outputs.
    logic [3:0] m_in0, m_in1;
    logic       m_cin;
    logic [4:0] m_tmp;
    always_comb begin
        m_in0 = 4'h0;
        m_in1 = 4'h0;
        m_cin = 1'b0;
        m_tmp = 5'h0;
        alu_result = 5'h0;
        case (alu_in0_sel)
            ALU_IN0_ACC:  m_in0 = acc;
            ALU_IN0_REG:  m_in0 = regval;
            ALU_IN0_DATA: m_in0 = alu_data;
            default:      m_in0 = 4'h0;
        endcase
        case (alu_in1_sel)
            ALU_IN1_REG:  m_in1 = regval;
            ALU_IN1_NREG: m_in1 = ~regval;
            ALU_IN1_ONE:  m_in1 = 4'h1;
            default:      m_in1 = 4'hE;
        endcase
        case (alu_cin_sel)
            ALU_CIN_CARRY:  m_cin = carry;
            ALU_CIN_NCARRY: m_cin = ~carry;
            ALU_CIN_ZERO:   m_cin = 1'b0;
            default:        m_cin = 1'b1;
        endcase
        case (alu_op)
            ALU_OP_ADD: alu_result = {1'b0, m_in0} + {1'b0, m_in1} + {4'h0, m_cin};
            ALU_OP_ROL: alu_result = {m_in0[3], m_in0[2:0], m_cin};
            ALU_OP_ROR: alu_result = {m_in0[0], m_cin, m_in0[3:1]};
            ALU_OP_DEC_A: begin
                if (m_in0 > 4'd9 || m_cin) begin
                    m_tmp = {1'b0, m_in0} + 5'd6;
                    alu_result = {m_cin | m_tmp[4], m_tmp[3:0]};
                end else begin
                    alu_result = {m_cin, m_in0};
                end
            end
            ALU_OP_LG2_1: begin
                case (m_in0)
                    4'h0: alu_result = 5'h00;
                    4'h1: alu_result = 5'h01;
                    4'h2: alu_result = 5'h02;
                    4'h4: alu_result = 5'h03;
                    4'h8: alu_result = 5'h04;
                    default: alu_result = 5'h0F;
                endcase
            end
            default: alu_result = {1'b0, m_in0};
        endcase
    end

    // Runs one full instruction cycle starting from X3; records any reg_we pulse.
    task automatic do_cycle(input logic [3:0] o, input logic [3:0] a);
        we_cnt = 0;
        we_idx = -1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            data_in = (i == 3) ? o : ((i == 4) ? a : 4'h0);
            if (reg_we) begin
                we_cnt++;
                we_idx  = i;
                we_data = reg_wdata;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; sync = 1'b0; data_in = 4'h0; regval = 4'h0;
        #12;
        vectors++; if (phase !== 3'd7) begin errors++; $display("FAIL reset_phase: got %0d expected 7", phase); end
        vectors++; if (acc !== 4'h0 || carry !== 1'b0) begin errors++; $display("FAIL reset_acc: got acc=%h c=%b expected acc=0 c=0", acc, carry); end
        vectors++; if (reg_we !== 1'b0 || reg_wdata !== 4'h0) begin errors++; $display("FAIL reset_we: got we=%b wd=%h expected 0/0", reg_we, reg_wdata); end
        vectors++; if (alu_op !== ALU_OP_PASS) begin errors++; $display("FAIL reset_aluop: got %0d expected %0d", alu_op, ALU_OP_PASS); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_phase;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            data_in = 4'h0;
            vectors++; if (phase !== 3'(i)) begin errors++; $display("FAIL phase_seq: got %0d expected %0d", phase, i); end
        end
    endtask

    task automatic test_add_sub;
        regval = 4'h8;
        do_cycle(4'hD, 4'h9);
        do_cycle(4'hF, ACC_STC);
        do_cycle(4'h8, 4'h3);
        vectors++; if (acc !== 4'h2 || carry !== 1'b1) begin errors++; $display("FAIL add: got acc=%h c=%b expected acc=2 c=1", acc, carry); end
        regval = 4'h5;
        do_cycle(4'hD, 4'h3);
        do_cycle(4'hF, ACC_CLC);
        do_cycle(4'h9, 4'h3);
        vectors++; if (acc !== 4'hE || carry !== 1'b0) begin errors++; $display("FAIL sub: got acc=%h c=%b expected acc=e c=0", acc, carry); end
    endtask

    task automatic test_acc_group;
        do_cycle(4'hD, 4'hA);
        do_cycle(4'hF, ACC_CLC);
        do_cycle(4'hF, ACC_RAL);
        vectors++; if (acc !== 4'h4 || carry !== 1'b1) begin errors++; $display("FAIL ral: got acc=%h c=%b expected acc=4 c=1", acc, carry); end
        do_cycle(4'hF, ACC_DAA);
        vectors++; if (acc !== 4'hA || carry !== 1'b1) begin errors++; $display("FAIL daa: got acc=%h c=%b expected acc=a c=1", acc, carry); end
        do_cycle(4'hD, 4'h8);
        do_cycle(4'hF, ACC_KBP);
        vectors++; if (acc !== 4'h4 || carry !== 1'b1) begin errors++; $display("FAIL kbp: got acc=%h c=%b expected acc=4 c=1", acc, carry); end
    endtask

    task automatic test_misc;
        do_cycle(4'hD, 4'hF);
        do_cycle(4'hF, ACC_CLC);
        do_cycle(4'hF, ACC_IAC);
        vectors++; if (acc !== 4'h0 || carry !== 1'b1) begin errors++; $display("FAIL iac_wrap: got acc=%h c=%b expected acc=0 c=1", acc, carry); end
        do_cycle(4'hF, ACC_CMC);
        vectors++; if (carry !== 1'b0) begin errors++; $display("FAIL cmc: got c=%b expected 0", carry); end
        do_cycle(4'hF, ACC_TCS);
        vectors++; if (acc !== 4'h9 || carry !== 1'b0) begin errors++; $display("FAIL tcs: got acc=%h c=%b expected acc=9 c=0", acc, carry); end
        do_cycle(4'hF, ACC_STC);
        do_cycle(4'hF, ACC_TCC);
        vectors++; if (acc !== 4'h1 || carry !== 1'b0) begin errors++; $display("FAIL tcc: got acc=%h c=%b expected acc=1 c=0", acc, carry); end
        do_cycle(4'hF, ACC_DAC);
        vectors++; if (acc !== 4'h0 || carry !== 1'b1) begin errors++; $display("FAIL dac: got acc=%h c=%b expected acc=0 c=1", acc, carry); end
        do_cycle(4'hF, ACC_CMA);
        vectors++; if (acc !== 4'hF || carry !== 1'b1) begin errors++; $display("FAIL cma: got acc=%h c=%b expected acc=f c=1", acc, carry); end
        do_cycle(4'hF, ACC_CLB);
        vectors++; if (acc !== 4'h0 || carry !== 1'b0) begin errors++; $display("FAIL clb: got acc=%h c=%b expected acc=0 c=0", acc, carry); end
        do_cycle(4'hD, 4'h5);
        do_cycle(4'hF, ACC_STC);
        do_cycle(4'hF, ACC_RAR);
        vectors++; if (acc !== 4'hA || carry !== 1'b1) begin errors++; $display("FAIL rar: got acc=%h c=%b expected acc=a c=1", acc, carry); end
    endtask

    task automatic test_two_word;
        do_cycle(4'hD, 4'h1);
        do_cycle(4'h4, 4'h0);
        do_cycle(4'hF, ACC_IAC);
        vectors++; if (acc !== 4'h1) begin errors++; $display("FAIL two_word_skip: got acc=%h expected 1", acc); end
        do_cycle(4'hF, ACC_IAC);
        vectors++; if (acc !== 4'h2) begin errors++; $display("FAIL two_word_resume: got acc=%h expected 2", acc); end
        do_cycle(4'h2, 4'h0);
        regval = 4'h3;
        do_cycle(4'hB, 4'h3);
        vectors++; if (acc !== 4'h2 || we_cnt !== 0) begin errors++; $display("FAIL fim_skip_xch: got acc=%h we=%0d expected acc=2 we=0", acc, we_cnt); end
    endtask

    task automatic test_xch_inc;
        regval = 4'hC;
        do_cycle(4'hD, 4'h7);
        do_cycle(4'hB, 4'h3);
        vectors++; if (acc !== 4'hC) begin errors++; $display("FAIL xch_acc: got %h expected c", acc); end
        vectors++; if (we_cnt !== 1 || we_idx !== 7 || we_data !== 4'h7) begin errors++; $display("FAIL xch_we: got cnt=%0d ph=%0d wd=%h expected cnt=1 ph=7 wd=7", we_cnt, we_idx, we_data); end
        do_cycle(4'h0, 4'h0);
        vectors++; if (we_cnt !== 0) begin errors++; $display("FAIL xch_we_once: got %0d pulses expected 0", we_cnt); end
        regval = 4'hF;
        do_cycle(4'hF, ACC_STC);
        do_cycle(4'h6, 4'h3);
        vectors++; if (we_cnt !== 1 || we_data !== 4'h0) begin errors++; $display("FAIL inc_we: got cnt=%0d wd=%h expected cnt=1 wd=0", we_cnt, we_data); end
        vectors++; if (acc !== 4'hC || carry !== 1'b1) begin errors++; $display("FAIL inc_keep: got acc=%h c=%b expected acc=c c=1", acc, carry); end
    endtask

    task automatic test_sync;
        do_cycle(4'hD, 4'h3);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            data_in = (i == 3) ? 4'hD : 4'h0;
            sync = (i == 3);
        end
        @(posedge clk);
        #1;
        sync = 1'b0;
        data_in = 4'h5;
        vectors++; if (phase !== 3'd0) begin errors++; $display("FAIL sync_resync: got phase=%0d expected 0", phase); end
        for (int i = 1; i < 8; i++) begin
            @(posedge clk);
            #1;
            data_in = 4'h0;
        end
        vectors++; if (acc !== 4'h3) begin errors++; $display("FAIL sync_abandon: got acc=%h expected 3", acc); end
        do_cycle(4'hD, 4'h6);
        vectors++; if (acc !== 4'h6) begin errors++; $display("FAIL sync_realign: got acc=%h expected 6", acc); end
    endtask

    task automatic test_reset_midcycle;
        do_cycle(4'hD, 4'h5);
        do_cycle(4'hF, ACC_STC);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            data_in = (i == 3) ? 4'hD : ((i == 4) ? 4'h9 : 4'h0);
        end
        rst_n = 1'b0;
        #1;
        vectors++; if (acc !== 4'h0 || carry !== 1'b0 || phase !== 3'd7) begin errors++; $display("FAIL reset_mid: got acc=%h c=%b ph=%0d expected acc=0 c=0 ph=7", acc, carry, phase); end
        data_in = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_first_a1: got %0d expected 0", phase); end
        for (int i = 1; i < 8; i++) begin
            @(posedge clk);
            #1;
        end
        vectors++; if (acc !== 4'h0) begin errors++; $display("FAIL reset_no_exec: got acc=%h expected 0", acc); end
    endtask

    initial begin
        test_reset();
        test_phase();
        test_add_sub();
        test_acc_group();
        test_misc();
        test_two_word();
        test_xch_inc();
        test_sync();
        test_reset_midcycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
